// File: rtl/shifter_stage_pkg.sv
// Shared CPU definitions for the shifter stage: shift-type encodings,
// ALU opcodes and the payload record carried from shifter to ALU.
package shifter_stage_pkg;

    localparam int unsigned CPU_XLEN = 32;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'h0,
        ALU_EOR = 4'h1,
        ALU_SUB = 4'h2,
        ALU_RSB = 4'h3,
        ALU_ADD = 4'h4,
        ALU_ADC = 4'h5,
        ALU_SBC = 4'h6,
        ALU_RSC = 4'h7,
        ALU_TST = 4'h8,
        ALU_TEQ = 4'h9,
        ALU_CMP = 4'hA,
        ALU_CMN = 4'hB,
        ALU_ORR = 4'hC,
        ALU_MOV = 4'hD,
        ALU_BIC = 4'hE,
        ALU_MVN = 4'hF
    } alu_op_e;

    // One registered operation as seen by the ALU.
    typedef struct packed {
        logic [CPU_XLEN-1:0] op_a;
        logic [CPU_XLEN-1:0] op_b;
        logic                shc;
        logic                cin;
        logic [3:0]          alu_op;
    } stage_payload_t;

endpackage

// File: rtl/shifter_stage_barrel_shifter.sv
// Combinational ARM-style barrel shifter (LSL/LSR/ASR/ROR, immediate and
// register amount forms, including the #0 / >=32 special encodings).
module barrel_shifter
    import shifter_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [1:0]       i_type,
    input  logic [7:0]       i_amt,
    input  logic             i_imm,
    input  logic             i_c_in,
    output logic [WIDTH-1:0] o_result,
    output logic             o_c_out
);

    logic [4:0]       w_n;
    logic [WIDTH:0]   w_lsl;
    logic [WIDTH:0]   w_lsr;
    logic [WIDTH:0]   w_asr;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_std_res;
    logic             w_std_c;
    logic             w_sign;
    logic             w_big;
    logic             w_eq32;

    // Standard 1..31 shifts; an extra guard bit captures the last bit shifted out.
    always_comb begin
        w_n       = i_amt[4:0];
        w_sign    = i_value[WIDTH-1];
        w_big     = |i_amt[7:5];
        w_eq32    = (i_amt == 8'd32);
        w_lsl     = {1'b0, i_value} << w_n;
        w_lsr     = {i_value, 1'b0} >> w_n;
        w_asr     = $signed({i_value, 1'b0}) >>> w_n;
        w_ror     = (i_value >> w_n) | (i_value << (6'd32 - {1'b0, w_n}));
        w_std_res = i_value;
        w_std_c   = i_c_in;
        case (i_type)
            SH_LSL:  begin w_std_res = w_lsl[WIDTH-1:0]; w_std_c = w_lsl[WIDTH]; end
            SH_LSR:  begin w_std_res = w_lsr[WIDTH:1];   w_std_c = w_lsr[0];     end
            SH_ASR:  begin w_std_res = w_asr[WIDTH:1];   w_std_c = w_asr[0];     end
            SH_ROR:  begin w_std_res = w_ror;            w_std_c = w_ror[WIDTH-1]; end
            default: begin w_std_res = i_value;          w_std_c = i_c_in;       end
        endcase
    end

    // Select between standard shift and the encoding-specific edge cases.
    always_comb begin
        o_result = i_value;
        o_c_out  = i_c_in;
        if (i_imm) begin
            if (w_n != 5'd0) begin
                o_result = w_std_res;
                o_c_out  = w_std_c;
            end else begin
                // #0 re-encodes LSR/ASR as #32 and ROR as RRX.
                case (i_type)
                    SH_LSR: begin o_result = '0;               o_c_out = w_sign;     end
                    SH_ASR: begin o_result = {WIDTH{w_sign}};  o_c_out = w_sign;     end
                    SH_ROR: begin o_result = {i_c_in, i_value[WIDTH-1:1]}; o_c_out = i_value[0]; end
                    default: begin o_result = i_value;         o_c_out = i_c_in;     end
                endcase
            end
        end else if (i_amt != 8'd0) begin
            case (i_type)
                SH_LSL: begin
                    if (w_big) begin
                        o_result = '0;
                        o_c_out  = w_eq32 ? i_value[0] : 1'b0;
                    end else begin
                        o_result = w_std_res;
                        o_c_out  = w_std_c;
                    end
                end
                SH_LSR: begin
                    if (w_big) begin
                        o_result = '0;
                        o_c_out  = w_eq32 ? w_sign : 1'b0;
                    end else begin
                        o_result = w_std_res;
                        o_c_out  = w_std_c;
                    end
                end
                SH_ASR: begin
                    if (w_big) begin
                        o_result = {WIDTH{w_sign}};
                        o_c_out  = w_sign;
                    end else begin
                        o_result = w_std_res;
                        o_c_out  = w_std_c;
                    end
                end
                default: begin
                    // Multiples of 32 leave the value unchanged but report bit 31.
                    if (w_n == 5'd0) begin
                        o_result = i_value;
                        o_c_out  = w_sign;
                    end else begin
                        o_result = w_std_res;
                        o_c_out  = w_std_c;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/shifter_stage.sv
// Pipeline register stage between operand fetch and the ALU: shifts Rm,
// forwards Rn/opcode/C flag, valid/ready handshake on both sides.
// Optional macro SHIFTER_SKID_EN adds a one-entry skid buffer with a
// registered in_ready.
module shifter_stage
    import shifter_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rn_data,
    input  logic [WIDTH-1:0] rm_data,
    input  logic [1:0]       shift_type,
    input  logic [7:0]       shift_amt,
    input  logic             shift_imm,
    input  logic             c_flag,
    input  logic [3:0]       alu_op_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             shifter_carry,
    output logic             alu_carry_in,
    output logic [3:0]       alu_op_out
);

    logic [WIDTH-1:0] w_shift_res;
    logic             w_shift_c;
    stage_payload_t   w_new;
    stage_payload_t   r_out;
    logic             r_valid;

    barrel_shifter #(.WIDTH(WIDTH)) u_barrel_shifter (
        .i_value  (rm_data),
        .i_type   (shift_type),
        .i_amt    (shift_amt),
        .i_imm    (shift_imm),
        .i_c_in   (c_flag),
        .o_result (w_shift_res),
        .o_c_out  (w_shift_c)
    );

    // Assemble the operation record offered by upstream this cycle.
    always_comb begin
        w_new        = '0;
        w_new.op_a   = rn_data;
        w_new.op_b   = w_shift_res;
        w_new.shc    = w_shift_c;
        w_new.cin    = c_flag;
        w_new.alu_op = alu_op_in;
    end

`ifdef SHIFTER_SKID_EN
    stage_payload_t r_skid;
    logic           r_skid_valid;
    logic           r_in_ready;
    logic           w_in_fire;

    assign in_ready  = r_in_ready;
    assign w_in_fire = in_valid & r_in_ready;

    // Output register refills from the skid first so ordering is kept;
    // the skid only catches an operation accepted while the output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (!r_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_valid      <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_in_fire) begin
                r_out   <= w_new;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end
`else
    assign in_ready = !r_valid | out_ready;

    // Single output register: load on input transfer, drain on output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (in_valid && in_ready) begin
            r_out   <= w_new;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif

    assign out_valid     = r_valid;
    assign op_a          = r_out.op_a;
    assign op_b          = r_out.op_b;
    assign shifter_carry = r_out.shc;
    assign alu_carry_in  = r_out.cin;
    assign alu_op_out    = r_out.alu_op;

endmodule

// File: tb/tb_shifter_stage.sv
module tb_shifter_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rn_data;
    logic [31:0] rm_data;
    logic [1:0]  shift_type;
    logic [7:0]  shift_amt;
    logic        shift_imm;
    logic        c_flag;
    logic [3:0]  alu_op_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        shifter_carry;
    logic        alu_carry_in;
    logic [3:0]  alu_op_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        shc;
        logic        cin;
        logic [3:0]  op;
    } exp_t;

    exp_t q[$];

    shifter_stage #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rn_data       (rn_data),
        .rm_data       (rm_data),
        .shift_type    (shift_type),
        .shift_amt     (shift_amt),
        .shift_imm     (shift_imm),
        .c_flag        (c_flag),
        .alu_op_in     (alu_op_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .shifter_carry (shifter_carry),
        .alu_carry_in  (alu_carry_in),
        .alu_op_out    (alu_op_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {carry, result} from the ARM shifter rules, via wide arithmetic.
    function automatic logic [32:0] model(input logic [31:0] v, input logic [1:0] t,
                                          input logic [7:0] amt, input logic imm, input logic c);
        int unsigned n;
        logic [63:0] w;
        logic [31:0] r;
        if (imm) begin
            n = amt[4:0];
            if (n == 0) begin
                case (t)
                    2'b00: return {c, v};
                    2'b01: n = 32;
                    2'b10: n = 32;
                    default: return {v[0], c, v[31:1]};
                endcase
            end
        end else begin
            n = amt;
        end
        if (n == 0) return {c, v};
        case (t)
            2'b00: begin
                w = {32'b0, v} << n;
                return {w[32], w[31:0]};
            end
            2'b01: begin
                w = {v, 32'b0} >> n;
                return {w[31], w[63:32]};
            end
            2'b10: begin
                w = $signed({v, 32'b0}) >>> ((n > 63) ? 63 : n);
                return {w[31], w[63:32]};
            end
            default: begin
                r = v;
                for (int unsigned k = 0; k < n % 32; k++) r = {r[0], r[31:1]};
                return {r[31], r};
            end
        endcase
    endfunction

    // Scoreboard: every input transfer enqueues, every output transfer dequeues.
    always @(posedge clk or negedge rst_n) begin
        logic [32:0] r;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                r = model(rm_data, shift_type, shift_amt, shift_imm, c_flag);
                q.push_back('{rn_data, r[31:0], r[32], c_flag, alu_op_in});
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
`ifdef SHIFTER_SKID_EN
            chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
`else
            chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() == 0) || out_ready});
`endif
            if (out_valid && q.size() > 0) begin
                chk("op_a", op_a, q[0].a);
                chk("op_b", op_b, q[0].b);
                chk("shifter_carry", {31'b0, shifter_carry}, {31'b0, q[0].shc});
                chk("alu_carry_in", {31'b0, alu_carry_in}, {31'b0, q[0].cin});
                chk("alu_op_out", {28'b0, alu_op_out}, {28'b0, q[0].op});
            end
        end
    end

    // Offer one operation (at negedge) and hold it until accepted; returns at the following negedge.
    task automatic send(input logic [31:0] rn, input logic [31:0] rm, input logic [1:0] t,
                        input logic [7:0] amt, input logic imm, input logic c, input logic [3:0] op);
        bit ok = 0;
        @(negedge clk);
        in_valid = 1'b1; rn_data = rn; rm_data = rm; shift_type = t;
        shift_amt = amt; shift_imm = imm; c_flag = c; alu_op_in = op;
        for (int i = 0; i < 50; i++) begin
            #2;
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_amt();
        case ($urandom_range(0, 7))
            0: return 8'd0;
            1: return 8'd31;
            2: return 8'd32;
            3: return 8'd33;
            4: return 8'd255;
            5: return 8'd64;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic rand_inputs();
        rn_data    = $urandom;
        rm_data    = $urandom;
        shift_type = 2'($urandom);
        shift_amt  = rand_amt();
        shift_imm  = 1'($urandom);
        c_flag     = 1'($urandom);
        alu_op_in  = 4'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] m;
        int          accepted;
        int          extra;
        logic [31:0] held_b;
        logic [31:0] held_a;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rn_data = '0; rm_data = '0; shift_type = '0; shift_amt = '0;
        shift_imm = 1'b0; c_flag = 1'b0; alu_op_in = '0;

        // Model pins against hand-computed values.
        m = model(32'h8000_000F, 2'b00, 8'd4, 1'b1, 1'b0);
        chk("model_lsl4", m[31:0], 32'h0000_00F0);
        chk("model_lsl4_c", {31'b0, m[32]}, 32'd0);
        m = model(32'h0000_0001, 2'b11, 8'd0, 1'b1, 1'b1);
        chk("model_rrx", m[31:0], 32'h8000_0000);
        chk("model_rrx_c", {31'b0, m[32]}, 32'd1);
        m = model(32'h8000_0000, 2'b01, 8'd32, 1'b0, 1'b0);
        chk("model_lsr32_c", {31'b0, m[32]}, 32'd1);
        m = model(32'h8000_0000, 2'b10, 8'd255, 1'b0, 1'b0);
        chk("model_asr255", m[31:0], 32'hFFFF_FFFF);

        // Reset state.
        #3;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_b", op_b, 32'd0);
        chk("rst_alu_op", {28'b0, alu_op_out}, 32'd0);
        chk("rst_carries", {30'b0, shifter_carry, alu_carry_in}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed literal cases, checked one cycle after accept.
        send(32'h1234_5678, 32'h8000_000F, 2'b00, 8'd4, 1'b1, 1'b0, 4'h4);
        chk("lsl4_op_b", op_b, 32'h0000_00F0);
        chk("lsl4_c", {31'b0, shifter_carry}, 32'd0);
        chk("lsl4_op_a", op_a, 32'h1234_5678);
        send(32'h0, 32'h0000_0001, 2'b11, 8'd0, 1'b1, 1'b1, 4'hD);
        chk("rrx_op_b", op_b, 32'h8000_0000);
        chk("rrx_c", {31'b0, shifter_carry}, 32'd1);
        send(32'h0, 32'h8000_0000, 2'b01, 8'd32, 1'b0, 1'b0, 4'hD);
        chk("lsr32_op_b", op_b, 32'h0);
        chk("lsr32_c", {31'b0, shifter_carry}, 32'd1);
        send(32'h0, 32'h8000_0000, 2'b01, 8'd40, 1'b0, 1'b1, 4'hD);
        chk("lsr40_op_b", op_b, 32'h0);
        chk("lsr40_c", {31'b0, shifter_carry}, 32'd0);
        send(32'h0, 32'h8000_0000, 2'b10, 8'd255, 1'b0, 1'b0, 4'hD);
        chk("asr255_op_b", op_b, 32'hFFFF_FFFF);
        chk("asr255_c", {31'b0, shifter_carry}, 32'd1);
        @(negedge clk);
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // Stream 4 ops with a 3-cycle stall mid-stream.
        accepted = 0;
        extra    = 0;
        in_valid = 1'b1;
        rand_inputs();
        for (int c = 0; c < 40 && accepted < 4; c++) begin
            #2;
            if (in_valid && in_ready) accepted++;
            @(negedge clk);
            rand_inputs();
            if (accepted == 2 && out_ready) begin
                out_ready = 1'b0;
                held_a = op_a;
                held_b = op_b;
                for (int s = 0; s < 3; s++) begin
                    #2;
                    if (in_valid && in_ready) begin accepted++; extra++; end
                    @(negedge clk);
                    rand_inputs();
                    chk("stall_hold_a", op_a, held_a);
                    chk("stall_hold_b", op_b, held_b);
                end
                out_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
`ifdef SHIFTER_SKID_EN
        chk("stall_extra_accepts", extra, 32'd1);
`else
        chk("stall_extra_accepts", extra, 32'd0);
`endif
        chk("stream_accepted", accepted, 32'd4);
        repeat (4) @(negedge clk);
        chk("stream_drained", q.size(), 32'd0);

        // Reset while an operation is stalled at the output.
        out_ready = 1'b0;
        send(32'hDEAD_BEEF, 32'hFFFF_FFFF, 2'b00, 8'd1, 1'b1, 1'b1, 4'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_op_a", op_a, 32'd0);
        chk("midrst_op_b", op_b, 32'd0);
        chk("midrst_rest", {26'b0, alu_op_out, shifter_carry, alu_carry_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("postrst_in_ready", {31'b0, in_ready}, 32'd1);
        send(32'h0, 32'h8000_000F, 2'b00, 8'd4, 1'b1, 1'b0, 4'h0);
        chk("postrst_op_b", op_b, 32'h0000_00F0);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_inputs();
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("final_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
